// File: rtl/state_scheduler.sv
// state_scheduler: top-level mode sequencer -- button pulses, shared slow tick, display mux, alarm.
// Optional feature: define BTN_DEBOUNCE_EN to debounce each synchronized button for DEBOUNCE_CYCLES cycles.
module state_scheduler #(
  parameter int NUM_STATES      = 4,
  parameter int TICK_DIV        = 50000000,
  parameter int BLINK_TICKS     = 1,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    modeBtn,
  input  logic                    pauseBtn,
  input  logic                    resetBtn,
  input  logic                    finished,
  input  logic [16*NUM_STATES-1:0] digitsIn,
  output logic [2:0]              currentState,
  output logic                    pauseOut,
  output logic                    resetOut,
  output logic                    slowTick,
  output logic [15:0]             digitsOut,
  output logic                    blank,
  output logic                    alarm
);

  localparam int TICK_W  = $clog2(TICK_DIV);
  localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  if (NUM_STATES < 2 || NUM_STATES > 8 || TICK_DIV < 2 || BLINK_TICKS < 1 ||
      DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("state_scheduler: parameter out of range");
  end

  typedef enum logic {RUN, ALARM} fsm_t;

  // Button path: bit 0 mode, bit 1 pause, bit 2 user reset.
  logic [2:0] btn_raw, btn_meta, btn_sync, btn_level, btn_level_q, btn_pulse;
  assign btn_raw = {resetBtn, pauseBtn, modeBtn};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_meta    <= '0;
      btn_sync    <= '0;
      btn_level_q <= '0;
      btn_pulse   <= '0;
    end else begin
      btn_meta    <= btn_raw;
      btn_sync    <= btn_meta;
      btn_level_q <= btn_level;
      btn_pulse   <= btn_level & ~btn_level_q;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [DB_W-1:0] db_cnt [3];

  // The level follows the synchronizer only after it has disagreed for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_level <= '0;
      for (int b = 0; b < 3; b++) db_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 3; b++) begin
        if (btn_sync[b] == btn_level[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          btn_level[b] <= btn_sync[b];
          db_cnt[b]    <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + 1'b1;
        end
      end
    end
  end
`else
  assign btn_level = btn_sync;
`endif

  logic mode_p, pause_p, user_rst_p, any_pulse;
  assign {user_rst_p, pause_p, mode_p} = btn_pulse;
  assign any_pulse = |btn_pulse;

  // finished edge detector; fin_armed masks a level that is already high at reset release.
  logic fin_q, fin_armed, fin_rise;
  assign fin_rise = fin_armed & finished & ~fin_q;

  fsm_t                fsm_q, fsm_d;
  logic [2:0]          state_d;
  logic                pause_d, user_rst_d, blank_d, state_change;
  logic [BLINK_W-1:0]  blink_cnt, blink_d;
  logic [TICK_W-1:0]   tick_cnt;
  logic [15:0]         digits_sel;

  assign alarm        = (fsm_q == ALARM);
  assign slowTick     = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign state_change = (state_d != currentState);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    fsm_d      = fsm_q;
    state_d    = currentState;
    pause_d    = 1'b0;
    user_rst_d = 1'b0;
    blank_d    = blank;
    blink_d    = blink_cnt;
    unique case (fsm_q)
      RUN: begin
        if (currentState == 3'd0 && fin_rise) begin
          fsm_d   = ALARM;
          blank_d = 1'b0;
          blink_d = '0;
        end else if (mode_p) begin
          state_d = (currentState == 3'(NUM_STATES - 1)) ? 3'd0 : currentState + 3'd1;
        end else begin
          pause_d    = pause_p;
          user_rst_d = user_rst_p;
        end
      end
      ALARM: begin
        if (any_pulse) begin
          fsm_d      = RUN;
          blank_d    = 1'b0;
          user_rst_d = 1'b1;
        end else if (slowTick) begin
          if (blink_cnt == BLINK_W'(BLINK_TICKS - 1)) begin
            blink_d = '0;
            blank_d = ~blank;
          end else begin
            blink_d = blink_cnt + 1'b1;
          end
        end
      end
      default: fsm_d = RUN;
    endcase
  end

  always_comb begin
    digits_sel = '0;
    for (int k = 0; k < NUM_STATES; k++) begin
      if (currentState == 3'(k)) digits_sel = digitsIn[16*k +: 16];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm_q        <= RUN;
      currentState <= 3'd0;
      pauseOut     <= 1'b0;
      resetOut     <= 1'b0;
      blank        <= 1'b0;
      blink_cnt    <= '0;
      digitsOut    <= 16'h0000;
      fin_q        <= 1'b0;
      fin_armed    <= 1'b0;
      tick_cnt     <= '0;
    end else begin
      fsm_q        <= fsm_d;
      currentState <= state_d;
      pauseOut     <= pause_d;
      resetOut     <= user_rst_d;
      blank        <= blank_d;
      blink_cnt    <= blink_d;
      digitsOut    <= digits_sel;
      fin_q        <= finished;
      fin_armed    <= 1'b1;
      // A new state always starts with a full tick period.
      if (state_change || slowTick) tick_cnt <= '0;
      else                          tick_cnt <= tick_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_state_scheduler.sv
// Directed self-checking bench for state_scheduler with a short tick period (TICK_DIV=10).
module tb_state_scheduler;

  localparam int NUM_STATES  = 4;
  localparam int TICK_DIV    = 10;
  localparam int BLINK_TICKS = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        modeBtn, pauseBtn, resetBtn, finished;
  logic [63:0] digitsIn;
  logic [2:0]  currentState;
  logic        pauseOut, resetOut, slowTick, blank, alarm;
  logic [15:0] digitsOut;

  logic [15:0] exp_digits [4];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign digitsIn = {exp_digits[3], exp_digits[2], exp_digits[1], exp_digits[0]};

  state_scheduler #(
    .NUM_STATES(NUM_STATES), .TICK_DIV(TICK_DIV), .BLINK_TICKS(BLINK_TICKS), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .modeBtn(modeBtn), .pauseBtn(pauseBtn), .resetBtn(resetBtn),
    .finished(finished), .digitsIn(digitsIn), .currentState(currentState), .pauseOut(pauseOut),
    .resetOut(resetOut), .slowTick(slowTick), .digitsOut(digitsOut), .blank(blank), .alarm(alarm)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press mode at a negedge (N0); state moves after the 4th posedge, display one cycle later.
  task automatic mode_step(input int from_st, input int to_st);
    modeBtn = 1'b1;
    step(1);
    modeBtn = 1'b0;
    step(2);
    check("mode_hold", currentState, from_st);
    step(1);
    check("mode_adv", currentState, to_st);
    check("disp_old", digitsOut, exp_digits[from_st]);
    step(1);
    check("disp_new", digitsOut, exp_digits[to_st]);
    step(7);
    check("tick_early", slowTick, 0);
    step(1);
    check("tick_full", slowTick, 1);
    step(7);
  endtask

  initial begin
    int pcount, rcount;
    logic found;
    exp_digits[0] = 16'h5959;
    exp_digits[1] = 16'h0101;
    exp_digits[2] = 16'h0202;
    exp_digits[3] = 16'h0303;
    reset = 1'b0; modeBtn = 1'b0; pauseBtn = 1'b0; resetBtn = 1'b0; finished = 1'b0;
    step(3);
    check("rst_state", currentState, 0);
    check("rst_pause", pauseOut, 0);
    check("rst_ureset", resetOut, 0);
    check("rst_tick", slowTick, 0);
    check("rst_digits", digitsOut, 16'h0000);
    check("rst_blank", blank, 0);
    check("rst_alarm", alarm, 0);

    // Tick period: high on cycles 10, 20, 30 after release.
    reset = 1'b1;
    for (int i = 1; i <= 35; i++) begin
      check($sformatf("tick_c%0d", i), slowTick, (i % 10 == 0) ? 1 : 0);
      if (i < 10) check("pre_alarm", alarm, 0);
      step(1);
    end

    mode_step(0, 1);
    mode_step(1, 2);
    mode_step(2, 3);
    mode_step(3, 0);
    mode_step(0, 1);

    // Held pause button: exactly one pauseOut pulse, 4 cycles after the edge.
    pauseBtn = 1'b1;
    pcount = 0; rcount = 0;
    for (int i = 1; i <= 50; i++) begin
      step(1);
      if (i == 3) check("pause_early", pauseOut, 0);
      if (i == 4) check("pause_lat", pauseOut, 1);
      if (pauseOut) pcount++;
      if (resetOut) rcount++;
    end
    check("pause_once", pcount, 1);
    check("pause_no_ureset", rcount, 0);
    pauseBtn = 1'b0;
    step(5);

    // Mode and pause together: mode wins, pause dropped.
    modeBtn = 1'b1; pauseBtn = 1'b1;
    step(1);
    modeBtn = 1'b0; pauseBtn = 1'b0;
    pcount = 0;
    for (int i = 2; i <= 8; i++) begin
      step(1);
      if (pauseOut) pcount++;
      if (i == 4) check("mp_state", currentState, 2);
    end
    check("mp_no_pause", pcount, 0);
    step(12);

    mode_step(2, 3);
    mode_step(3, 0);

    // Alarm: tick counter is at 6 here, so the first tick lands on F+3.
    finished = 1'b1;
    step(1);
    check("alm_on", alarm, 1);
    check("alm_blank0", blank, 0);
    check("alm_state", currentState, 0);
    step(2);
    check("alm_tick1", slowTick, 1);
    check("alm_blank_pre", blank, 0);
    step(1);
    check("alm_blank_t1", blank, 1);
    step(9);
    check("alm_tick2", slowTick, 1);
    step(1);
    check("alm_blank_t2", blank, 0);
    step(10);
    check("alm_blank_t3", blank, 1);

    // Acknowledge with mode: alarm clears, one resetOut, no state advance.
    modeBtn = 1'b1;
    step(1);
    modeBtn = 1'b0;
    step(2);
    check("ack_hold", alarm, 1);
    step(1);
    check("ack_alarm", alarm, 0);
    check("ack_blank", blank, 0);
    check("ack_ureset", resetOut, 1);
    check("ack_state", currentState, 0);
    step(1);
    check("ack_ureset_end", resetOut, 0);
    step(3);
    check("ack_state_hold", currentState, 0);

    // Re-enter alarm, then reset while blank is high.
    finished = 1'b0;
    step(2);
    finished = 1'b1;
    step(1);
    check("alm2_on", alarm, 1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (blank) found = 1'b1;
      else step(1);
    end
    check("alm2_blank_seen", found, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_alarm", alarm, 0);
    check("mid_rst_blank", blank, 0);
    check("mid_rst_state", currentState, 0);
    check("mid_rst_digits", digitsOut, 16'h0000);
    check("mid_rst_ureset", resetOut, 0);
    step(2);
    reset = 1'b1;

    // finished already high at release is not an edge.
    step(6);
    check("fin_high_release", alarm, 0);

    // Pause and user reset together: both forwarded.
    pauseBtn = 1'b1; resetBtn = 1'b1;
    step(1);
    pauseBtn = 1'b0; resetBtn = 1'b0;
    step(3);
    check("pr_pause", pauseOut, 1);
    check("pr_ureset", resetOut, 1);
    step(1);
    check("pr_pause_end", pauseOut, 0);
    check("pr_ureset_end", resetOut, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
